muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have the port Clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have the port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port Start, input, 1 bit: begin an operation; sampled only in IDLE or DONE.
REQ-004 The block SHALL have the port Op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with Start.
REQ-005 The block SHALL have the ports SrcA and SrcB, input, 32 bits each: multiplicand/dividend (A) and multiplier/divisor (B); captured with Start.
REQ-006 The block SHALL have the port Flush, input, 1 bit: abort the in-flight operation (branch/jump squash from the hazard logic).
REQ-007 The block SHALL have the port Busy, output, 1 bit: high in PREP, ITER and FIX.
REQ-008 The block SHALL have the port Stall, output, 1 bit: combinational (Start & ~Flush) | Busy; drives PCWrite/IF_ID_Write hold in the pipeline.
REQ-009 The block SHALL have the port Done, output, 1 bit: one-cycle pulse in DONE.
REQ-010 The block SHALL have the ports Hi and Lo, output, 32 bits each: registered result.
REQ-011 The block SHALL have the port DivByZero, output, 1 bit: high with Done when a divide had SrcB==0.

Function
REQ-012 The FSM SHALL have states IDLE, PREP, ITER, FIX and DONE.
- IDLE/DONE + Start -> PREP.
- DONE without Start -> IDLE.
REQ-013 PREP (1 cycle) SHALL latch operand magnitudes and result signs.
- Signed ops: magnitude = two's-complement absolute value.
- Unsigned ops: operands unchanged.
REQ-014 ITER SHALL last exactly 32 cycles, counted by a 5-bit counter that wraps 31->0 on the exit edge.
- Multiply: shift-add, 1 multiplier bit per cycle, 64-bit product.
- Divide: restoring, 1 quotient bit per cycle.
REQ-015 FIX (1 cycle) SHALL apply signs and write Hi/Lo.
- Multiply: {Hi,Lo} = 64-bit signed/unsigned product.
- Divide: Lo = quotient, negated when operand signs differ; Hi = remainder, with the sign of the dividend.
REQ-016 Latency SHALL be fixed: Start sampled at edge 0 -> Done high during cycle 35.
REQ-017 Divide with SrcB==0 SHALL go PREP -> DONE, skipping ITER and FIX.
- Done during cycle 2.
- Hi = SrcA, Lo = 32'hFFFFFFFF, DivByZero = 1.
REQ-018 0x80000000 / -1 (DIV) SHALL produce Lo = 0x80000000, Hi = 0, with no flag.
REQ-019 Start while Busy SHALL be ignored; operands are not re-captured.
REQ-020 Flush SHALL take priority over Start, and when high in any state it SHALL force IDLE at the next edge.
- Hi/Lo keep their pre-operation values.
- Done is not pulsed.
REQ-021 Hi/Lo SHALL change only on the FIX edge or the divide-by-zero DONE edge, and SHALL otherwise hold indefinitely.
REQ-022 DivByZero SHALL be 0 whenever Done is 0.

Reset
REQ-023 Rst_n low SHALL asynchronously force the following, including mid-operation, where no partial result is kept:
- state IDLE;
- counter 0;
- Hi = Lo = 0;
- Done = DivByZero = 0.
REQ-024 While Rst_n is low, Busy and Stall SHALL be 0, and Start SHALL be ignored.
REQ-025 The first Start SHALL be accepted on the first rising edge after Rst_n deasserts.

Configuration
REQ-026 Divide support SHALL be compiled in only when MULDIV_DIV_EN is defined.
- Without it: Op 10/11 go PREP -> DONE with Done during cycle 2, Hi = Lo = 0 and DivByZero = 0.
- Without it: no divide datapath is synthesized.
- Multiply behaviour SHALL be identical with or without the macro.

Structure
REQ-027 Package muldiv_pkg SHALL hold:
- the Op encoding constants;
- the FSM state encoding;
- ITER_COUNT = 32;
- the divide-by-zero Lo constant 32'hFFFFFFFF.
REQ-028 The shift/add/subtract registers SHALL live in sub-module muldiv_datapath, controlled by step/load/fix strobes from the sequencer FSM.

Verification
REQ-029 MULT SrcA=-3, SrcB=7 -> Done at cycle 35, Hi=FFFFFFFF, Lo=FFFFFFEB, Stall high in cycles 0-34.
REQ-030 MULTU FFFFFFFF x FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001 at cycle 35.
REQ-031 DIV -7 / 2 -> Lo=FFFFFFFD, Hi=FFFFFFFF; DIVU 100 / 7 -> Lo=0000000E, Hi=00000002.
REQ-032 DIVU 5 / 0 -> Done and DivByZero at cycle 2, Hi=00000005, Lo=FFFFFFFF; then Busy=0.
REQ-033 Flush during cycle 10 of a MULT after a prior result Hi=1/Lo=2 -> Busy=0 at cycle 11, no Done, Hi/Lo stay 1/2; a Start raised together with Flush is ignored.
REQ-034 Rst_n low at cycle 20 of a DIV -> outputs are 0 immediately; a new MULT 2x3 started after release gives Lo=6, Hi=0 at 35 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned PROD_W     = 2 * XLEN;
  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = 5;
  localparam logic [XLEN-1:0] DBZ_LO = 32'hFFFF_FFFF;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_ENABLED = 1'b1;
`else
  localparam bit DIV_ENABLED = 1'b0;
`endif

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Datapath strobes issued by the sequencer FSM
  typedef struct packed {
    logic capture;
    logic load;
    logic step;
    logic fix;
    logic early;
  } dp_ctrl_t;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide registers and result formatting.
// The divide step and sign fix-up exist only when MULDIV_DIV_EN is defined.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  dp_ctrl_t        i_ctrl,
  input  op_e             i_op,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  output logic            o_b_zero,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN-1:0]   r_acc, r_q, r_b, r_hi, r_lo;
  logic              r_neg_q;
  logic              w_neg_a, w_neg_b;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic [XLEN:0]     w_mul_sum;
  logic [PROD_W-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0]   w_next_acc, w_next_q, w_fix_hi, w_fix_lo;

  // r_q/r_b still hold the raw operands while in PREP
  assign w_neg_a  = op_is_signed(i_op) & r_q[XLEN-1];
  assign w_neg_b  = op_is_signed(i_op) & r_b[XLEN-1];
  assign w_mag_a  = w_neg_a ? (~r_q + 1'b1) : r_q;
  assign w_mag_b  = w_neg_b ? (~r_b + 1'b1) : r_b;
  assign o_b_zero = (r_b == '0);

  assign w_mul_sum  = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_b : {XLEN{1'b0}})};
  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_neg_q ? (~w_prod + PROD_W'(1)) : w_prod;

`ifdef MULDIV_DIV_EN
  logic          r_neg_r;
  logic [XLEN:0] w_shift, w_diff;
  logic          w_ge;

  // Remainder < divisor, so a clear borrow bit means the trial subtract fits
  assign w_shift = {r_acc, r_q[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_ge    = ~w_diff[XLEN];

  always_comb begin
    w_next_acc = w_mul_sum[XLEN:1];
    w_next_q   = {w_mul_sum[0], r_q[XLEN-1:1]};
    w_fix_hi   = w_prod_fix[PROD_W-1:XLEN];
    w_fix_lo   = w_prod_fix[XLEN-1:0];
    if (op_is_div(i_op)) begin
      w_next_acc = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      w_next_q   = {r_q[XLEN-2:0], w_ge};
      w_fix_hi   = r_neg_r ? (~r_acc + 1'b1) : r_acc;
      w_fix_lo   = r_neg_q ? (~r_q + 1'b1) : r_q;
    end
  end
`else
  always_comb begin
    w_next_acc = w_mul_sum[XLEN:1];
    w_next_q   = {w_mul_sum[0], r_q[XLEN-1:1]};
    w_fix_hi   = w_prod_fix[PROD_W-1:XLEN];
    w_fix_lo   = w_prod_fix[XLEN-1:0];
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_neg_r <= 1'b0;
`endif
    end else begin
      if (i_ctrl.capture) begin
        r_q <= i_src_a;
        r_b <= i_src_b;
      end else if (i_ctrl.load) begin
        r_q     <= w_mag_a;
        r_b     <= w_mag_b;
        r_acc   <= '0;
        r_neg_q <= w_neg_a ^ w_neg_b;
`ifdef MULDIV_DIV_EN
        r_neg_r <= w_neg_a;
`endif
      end else if (i_ctrl.step) begin
        r_acc <= w_next_acc;
        r_q   <= w_next_q;
      end
      // Early exit: divide-by-zero result, or zeros when divide is absent
      if (i_ctrl.fix) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else if (i_ctrl.early) begin
        r_hi <= DIV_ENABLED ? r_q : '0;
        r_lo <= DIV_ENABLED ? DBZ_LO : '0;
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle MULT/MULTU/DIV/DIVU sequencer with pipeline stall and flush.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Start,
  input  logic [1:0]      Op,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Flush,
  output logic            Busy,
  output logic            Stall,
  output logic            Done,
  output logic [XLEN-1:0] Hi,
  output logic [XLEN-1:0] Lo,
  output logic            DivByZero
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  op_e              r_op, w_op_next;
  logic             r_busy, r_done, r_dbz;
  logic             w_busy_next, w_done_next, w_dbz_next;
  logic             w_b_zero, w_early;
  dp_ctrl_t         w_ctrl;

  assign w_early = op_is_div(r_op) & (~DIV_ENABLED | w_b_zero);

  // Next state, datapath strobes and registered-output next values
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_op_next    = r_op;
    w_ctrl       = '0;
    w_dbz_next   = 1'b0;
    w_done_next  = 1'b0;
    w_busy_next  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          w_state_next   = S_PREP;
          w_op_next      = op_e'(Op);
          w_ctrl.capture = 1'b1;
        end else if (r_state == S_DONE) begin
          w_state_next = S_IDLE;
        end
      end
      S_PREP: begin
        if (w_early) begin
          w_state_next = S_DONE;
          w_ctrl.early = 1'b1;
          w_dbz_next   = DIV_ENABLED & w_b_zero;
        end else begin
          w_state_next = S_ITER;
          w_ctrl.load  = 1'b1;
          w_cnt_next   = '0;
        end
      end
      S_ITER: begin
        w_ctrl.step = 1'b1;
        w_cnt_next  = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) w_state_next = S_FIX;
      end
      S_FIX: begin
        w_ctrl.fix   = 1'b1;
        w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // Squash wins over everything, including a simultaneous Start
    if (Flush) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_op_next    = r_op;
      w_ctrl       = '0;
      w_dbz_next   = 1'b0;
    end
    w_done_next = (w_state_next == S_DONE);
    w_busy_next = (w_state_next == S_PREP) || (w_state_next == S_ITER) ||
                  (w_state_next == S_FIX);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_MULT;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_op    <= w_op_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_dbz   <= w_dbz_next;
    end
  end

  muldiv_datapath u_datapath (
    .i_clk    (Clk),
    .i_rst_n  (Rst_n),
    .i_ctrl   (w_ctrl),
    .i_op     (r_op),
    .i_src_a  (SrcA),
    .i_src_b  (SrcB),
    .o_b_zero (w_b_zero),
    .o_hi     (Hi),
    .o_lo     (Lo)
  );

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign DivByZero = r_dbz;
  assign Stall     = Rst_n & ((Start & ~Flush) | r_busy);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic model.
// Expectations follow MULDIV_DIV_EN so the same bench covers both builds.
module tb_muldiv_sequencer;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Flush;
  logic        Busy;
  logic        Stall;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        DivByZero;

  int n_checks;
  int n_errors;

  muldiv_sequencer dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Op        (Op),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Flush     (Flush),
    .Busy      (Busy),
    .Stall     (Stall),
    .Done      (Done),
    .Hi        (Hi),
    .Lo        (Lo),
    .DivByZero (DivByZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result and Done latency (cycles after the Start edge)
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] hi,
                                    output logic [31:0] lo, output logic dbz,
                                    output int lat);
    logic [63:0] p;
    int sa;
    int sb;
    sa  = $signed(a);
    sb  = $signed(b);
    hi  = 32'd0;
    lo  = 32'd0;
    dbz = 1'b0;
    lat = 35;
    p   = 64'd0;
    case (op)
      2'b00: begin
        p  = longint'(sa) * longint'(sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b01: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          lat = 2;
          hi  = a;
          lo  = 32'hFFFF_FFFF;
          dbz = 1'b1;
        end else if (op == 2'b11) begin
          lo = a / b;
          hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'd0;
        end else begin
          lo = 32'(sa / sb);
          hi = 32'(sa % sb);
        end
`else
        lat = 2;
`endif
      end
    endcase
  endfunction

  // Called at a negedge; Start is sampled at the next posedge (edge 0)
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit chain, input int poke);
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
    int          elat;
    int          lat;
    int          stalls;
    ref_model(op, a, b, ehi, elo, edbz, elat);
    Start = 1'b1;
    Op    = op;
    SrcA  = a;
    SrcB  = b;
    #1 check("stall_c0", 64'(Stall), 64'd1);
    @(posedge Clk);
    lat    = 0;
    stalls = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge Clk);
      if (Done) begin
        lat = n;
        break;
      end
      stalls += int'(Stall);
      Start = (poke != 0) && (n == poke);
      if (Start) begin
        Op   = ~op;
        SrcA = $urandom;
        SrcB = $urandom;
      end
    end
    Start = 1'b0;
    check("latency", 64'(lat), 64'(elat));
    check("hi", 64'(Hi), 64'(ehi));
    check("lo", 64'(Lo), 64'(elo));
    check("dbz", 64'(DivByZero), 64'(edbz));
    check("stall_cycles", 64'(stalls), 64'(elat - 1));
    if (!chain) begin
      @(negedge Clk);
      check("done_pulse", 64'(Done), 64'd0);
      check("dbz_low", 64'(DivByZero), 64'd0);
      check("idle_busy", 64'(Busy), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          k;
    bit          seen;
    n_checks = 0;
    n_errors = 0;
    Rst_n = 1'b0;
    Start = 1'b1;
    Flush = 1'b0;
    Op    = 2'b00;
    SrcA  = 32'h1234_5678;
    SrcB  = 32'h9ABC_DEF0;
    repeat (3) @(negedge Clk);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_stall", 64'(Stall), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_dbz", 64'(DivByZero), 64'd0);
    check("rst_hi", 64'(Hi), 64'd0);
    check("rst_lo", 64'(Lo), 64'd0);
    Rst_n = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 0);
    run_op(2'b11, 32'd5, 32'd0, 1'b0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);

    // Flush mid-multiply with a concurrent Start
    run_op(2'b01, 32'd2, 32'h8000_0001, 1'b0, 0);
    Start = 1'b1;
    Op    = 2'b00;
    SrcA  = 32'd5;
    SrcB  = 32'd9;
    @(posedge Clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge Clk);
      if (n == 1) Start = 1'b0;
      if (n == 10) begin
        Start = 1'b1;
        Flush = 1'b1;
      end
    end
    @(negedge Clk);
    check("flush_busy", 64'(Busy), 64'd0);
    check("flush_stall", 64'(Stall), 64'd0);
    @(negedge Clk);
    check("flush_start_ign", 64'(Busy), 64'd0);
    Start = 1'b0;
    Flush = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) seen = 1'b1;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hi", 64'(Hi), 64'd1);
    check("flush_lo", 64'(Lo), 64'd2);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      k   = $urandom_range(0, 7);
      if (k == 0) rb = 32'd0;
      else if (k == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end else if (k == 2) begin
        ra = 32'($urandom_range(0, 300));
        rb = 32'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) ra = ~ra + 32'd1;
        if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
      end
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 30)) : 0);
    end

    // Asynchronous reset in the middle of an operation
    run_op(2'b01, 32'd3, 32'd5, 1'b0, 0);
    Start = 1'b1;
    Op    = 2'b10;
    SrcA  = 32'd1000;
    SrcB  = 32'd7;
    @(posedge Clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clk);
      if (n == 1) Start = 1'b0;
    end
    Rst_n = 1'b0;
    Start = 1'b1;
    #1;
    check("mid_rst_hi", 64'(Hi), 64'd0);
    check("mid_rst_lo", 64'(Lo), 64'd0);
    check("mid_rst_done", 64'(Done), 64'd0);
    check("mid_rst_dbz", 64'(DivByZero), 64'd0);
    check("mid_rst_busy", 64'(Busy), 64'd0);
    check("mid_rst_stall", 64'(Stall), 64'd0);
    @(posedge Clk);
    #1;
    check("rst_start_ign", 64'(Busy), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    Start = 1'b0;
    run_op(2'b00, 32'd2, 32'd3, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
